// File: rtl/fp_scaleb_if.sv
// fp_scaleb_if: operand/result bundle for fp_scaleb_pipe.
// With FP_SCALEB_EXC_EN defined the bundle also carries exc[3:0].
interface fp_scaleb_if #(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10,
    parameter int BW     = 16
);
    logic                    ce;
    logic                    valid_i;
    logic [EXP_W+FRAC_W:0]   a;
    logic [BW-1:0]           b;
    logic                    valid_o;
    logic [EXP_W+FRAC_W:0]   o;
`ifdef FP_SCALEB_EXC_EN
    logic [3:0]              exc;

    modport master (
        output ce, valid_i, a, b,
        input  valid_o, o, exc
    );
    modport slave (
        input  ce, valid_i, a, b,
        output valid_o, o, exc
    );
`else
    modport master (
        output ce, valid_i, a, b,
        input  valid_o, o
    );
    modport slave (
        input  ce, valid_i, a, b,
        output valid_o, o
    );
`endif
endinterface

// File: rtl/fp_scaleb_pipe.sv
// fp_scaleb_pipe: 3-stage IEEE-754 scaleb o = a * 2^b with RNE rounding.
// Define FP_SCALEB_EXC_EN to add exc[3:0] = {invalid, overflow, underflow, inexact}.
module fp_scaleb_pipe #(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10,
    parameter int BW     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    fp_scaleb_if.slave bus
);
    localparam int FW  = 1 + EXP_W + FRAC_W;
    localparam int EW  = EXP_W + 2;
    localparam int SW  = EXP_W + BW + 2;
    localparam int LZW = $clog2(FRAC_W + 1);
    localparam int TW  = FRAC_W + 3;
    localparam int SHW = $clog2(TW);

    localparam logic signed [SW-1:0] S_MAX = SW'((1 << EXP_W) - 1);
    localparam logic signed [SW-1:0] S_ONE = SW'(1);
    localparam logic signed [SW-1:0] S_SHC = SW'(TW - 1);
    localparam logic [FRAC_W-1:0]    QBIT  = {1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [1:0] {CL_FIN, CL_ZERO, CL_INF, CL_NAN} cls_e;

    logic              a_sgn;
    logic [EXP_W-1:0]  a_exp;
    logic [FRAC_W-1:0] a_frac;
    logic              frac_nz;
    logic [LZW-1:0]    lz;

    assign {a_sgn, a_exp, a_frac} = bus.a;
    assign frac_nz = |a_frac;

    cls_e                 cls1_d, cls1_q;
    logic signed [EW-1:0] e1_d, e1_q;
    logic [FRAC_W:0]      m1_d, m1_q;
    logic signed [BW-1:0] b1_q;
    logic                 v1_q, s1_q;

    // Leading-zero count of the fraction; highest set bit wins.
    always_comb begin
        lz = '0;
        for (int i = 0; i < FRAC_W; i++)
            if (a_frac[i]) lz = LZW'(FRAC_W - 1 - i);
    end

    // Classify a and normalise subnormals to an implicit-one significand.
    always_comb begin
        cls1_d = CL_FIN;
        e1_d   = EW'(a_exp);
        m1_d   = {1'b1, a_frac};
        if (&a_exp) begin
            cls1_d = frac_nz ? CL_NAN : CL_INF;
            m1_d   = {1'b0, a_frac | (frac_nz ? QBIT : '0)};
        end else if (a_exp == '0) begin
            if (!frac_nz) begin
                cls1_d = CL_ZERO;
                m1_d   = '0;
            end else begin
                e1_d = -EW'(lz);
                m1_d = {1'b1, a_frac << (lz + LZW'(1))};
            end
        end
    end

`ifdef FP_SCALEB_EXC_EN
    logic inv1_q;
`endif

    // Stage 1 registers: sign, class, exponent, significand and scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            s1_q   <= 1'b0;
            cls1_q <= CL_ZERO;
            e1_q   <= '0;
            m1_q   <= '0;
            b1_q   <= '0;
`ifdef FP_SCALEB_EXC_EN
            inv1_q <= 1'b0;
`endif
        end else if (bus.ce) begin
            v1_q   <= bus.valid_i;
            s1_q   <= a_sgn;
            cls1_q <= cls1_d;
            e1_q   <= e1_d;
            m1_q   <= m1_d;
            b1_q   <= bus.b;
`ifdef FP_SCALEB_EXC_EN
            inv1_q <= (cls1_d == CL_NAN) && !a_frac[FRAC_W-1];
`endif
        end
    end

    logic signed [SW-1:0] s_sum, sh_m1;
    logic [SHW-1:0]       shc;
    logic [2*TW-2:0]      wide;
    logic [EXP_W-1:0]     exp2_d, exp2_q;
    logic [FRAC_W-1:0]    frac2_d, frac2_q;
    logic [2:0]           grs2_d, grs2_q;
    logic                 tiny2_d;
    logic                 v2_q, s2_q;

    // Scale: wide signed exponent sum, then overflow / normal / denormalise.
    always_comb begin
        s_sum   = SW'(e1_q) + SW'(b1_q);
        sh_m1   = -s_sum;
        shc     = (sh_m1 > S_SHC) ? SHW'(TW - 1) : SHW'(sh_m1);
        wide    = {m1_q, 2'b00, {(TW-1){1'b0}}} >> shc;
        exp2_d  = '0;
        frac2_d = m1_q[FRAC_W-1:0];
        grs2_d  = '0;
        tiny2_d = 1'b0;
        unique case (cls1_q)
            CL_NAN, CL_INF: exp2_d = '1;
            CL_ZERO:        frac2_d = '0;
            CL_FIN: begin
                if (s_sum >= S_MAX) begin
                    exp2_d  = '1;
                    frac2_d = '0;
                end else if (s_sum >= S_ONE) begin
                    exp2_d = s_sum[EXP_W-1:0];
                end else begin
                    frac2_d = wide[2*TW-2:TW+2];
                    grs2_d  = {wide[TW+1], wide[TW], |wide[TW-1:0]};
                    tiny2_d = 1'b1;
                end
            end
        endcase
    end

`ifdef FP_SCALEB_EXC_EN
    logic inv2_q, fin2_q, tiny2_q;
`endif

    // Stage 2 registers: pre-rounding exponent/fraction and rounding bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            s2_q    <= 1'b0;
            exp2_q  <= '0;
            frac2_q <= '0;
            grs2_q  <= '0;
`ifdef FP_SCALEB_EXC_EN
            inv2_q  <= 1'b0;
            fin2_q  <= 1'b0;
            tiny2_q <= 1'b0;
`endif
        end else if (bus.ce) begin
            v2_q    <= v1_q;
            s2_q    <= s1_q;
            exp2_q  <= exp2_d;
            frac2_q <= frac2_d;
            grs2_q  <= grs2_d;
`ifdef FP_SCALEB_EXC_EN
            inv2_q  <= inv1_q;
            fin2_q  <= cls1_q == CL_FIN;
            tiny2_q <= tiny2_d;
`endif
        end
    end

    logic                    inc;
    logic [EXP_W+FRAC_W-1:0] rnd;
    logic                    v3_q;
    logic [FW-1:0]           o3_q;

    // Carry out of the fraction rolls into the exponent: subnormal -> min
    // normal, and largest finite -> Inf fall out of the same add.
    assign inc = grs2_q[2] & (grs2_q[1] | grs2_q[0] | frac2_q[0]);
    assign rnd = {exp2_q, frac2_q} + (EXP_W+FRAC_W)'(inc);

`ifdef FP_SCALEB_EXC_EN
    logic       ovf3;
    logic [3:0] exc3_q;
    assign ovf3 = fin2_q & (&rnd[EXP_W+FRAC_W-1:FRAC_W]);
`else
    logic unused_tiny;
    assign unused_tiny = tiny2_d;
`endif

    // Stage 3 registers: rounded result and valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q   <= 1'b0;
            o3_q   <= '0;
`ifdef FP_SCALEB_EXC_EN
            exc3_q <= '0;
`endif
        end else if (bus.ce) begin
            v3_q   <= v2_q;
            o3_q   <= {s2_q, rnd};
`ifdef FP_SCALEB_EXC_EN
            exc3_q <= {inv2_q, ovf3, tiny2_q & (|grs2_q),
                       (|grs2_q) | ovf3};
`endif
        end
    end

    assign bus.valid_o = v3_q;
    assign bus.o       = o3_q;
`ifdef FP_SCALEB_EXC_EN
    assign bus.exc     = exc3_q;
`endif
endmodule

// File: tb/tb_fp_scaleb_pipe.sv
// tb_fp_scaleb_pipe: directed fp16 vectors for fp_scaleb_pipe.
// Checks latency, rounding, specials, ce stalls and async reset.
module tb_fp_scaleb_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    fp_scaleb_if #(.EXP_W(5), .FRAC_W(10), .BW(16)) bus ();

    fp_scaleb_pipe #(.EXP_W(5), .FRAC_W(10), .BW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] a,
                         input logic [15:0] b);
        bus.valid_i = v;
        bus.a       = a;
        bus.b       = b;
    endtask

    // xe[4] enables the flag check, xe[3:0] is the expected exc.
    task automatic run_op(input string tag, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp,
                          input logic [4:0] xe);
        bus.ce = 1'b1;
        drive(1'b1, a, b);
        step();
        drive(1'b0, 16'h0, 16'h0);
        step();
        chk({tag, ".v2"}, 32'(bus.valid_o), 32'd0);
        step();
        chk({tag, ".v"}, 32'(bus.valid_o), 32'd1);
        chk({tag, ".o"}, 32'(bus.o), 32'(exp));
`ifdef FP_SCALEB_EXC_EN
        if (xe[4]) chk({tag, ".exc"}, 32'(bus.exc), 32'(xe[3:0]));
`endif
        step();
        chk({tag, ".v4"}, 32'(bus.valid_o), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ce = 1'b1;
        drive(1'b1, 16'h3C00, 16'h0001);
        step();
        step();
        chk("rst.v", 32'(bus.valid_o), 32'd0);
        chk("rst.o", 32'(bus.o), 32'd0);
        drive(1'b0, 16'h0, 16'h0);
        rst_n = 1'b1;
        step();

        run_op("one_b3",    16'h3C00, 16'h0003, 16'h4800, 5'b0_0000);
        run_op("one_bm24",  16'h3C00, 16'hFFE8, 16'h0001, 5'b1_0000);
        run_op("one_bm25",  16'h3C00, 16'hFFE7, 16'h0000, 5'b1_0011);
        run_op("1p5_bm25",  16'h3E00, 16'hFFE7, 16'h0001, 5'b1_0011);
        run_op("sub_b24",   16'h0001, 16'h0018, 16'h3C00, 5'b1_0000);
        run_op("max_b1",    16'h7BFF, 16'h0001, 16'h7C00, 5'b1_0101);
        run_op("one_bmax",  16'h3C00, 16'h7FFF, 16'h7C00, 5'b1_0101);
        run_op("one_bmin",  16'h3C00, 16'h8000, 16'h0000, 5'b1_0011);
        run_op("snan_b5",   16'h7D00, 16'h0005, 16'h7F00, 5'b1_1000);
        run_op("ninf",      16'hFC00, 16'hFF9C, 16'hFC00, 5'b1_0000);
        run_op("nzero",     16'h8000, 16'h0014, 16'h8000, 5'b1_0000);
        run_op("rnd_carry", 16'h3FFF, 16'hFFF1, 16'h0400, 5'b0_0000);
        run_op("sub_b0",    16'h0155, 16'h0000, 16'h0155, 5'b1_0000);
        run_op("nnorm_b0",  16'hC123, 16'h0000, 16'hC123, 5'b1_0000);
        run_op("snan_b0",   16'h7D00, 16'h0000, 16'h7F00, 5'b1_1000);
        run_op("neg_bm3",   16'hC400, 16'hFFFD, 16'hB800, 5'b1_0000);

        // ce toggling: ops 1.0 * 2^i, inputs ignored while ce=0.
        for (int i = 0; i < 10; i++) begin
            bus.ce = 1'b1;
            if (i < 8) drive(1'b1, 16'h3C00, 16'(i));
            else       drive(1'b0, 16'h0, 16'h0);
            step();
            for (int h = 0; h < 2; h++) begin
                if (i >= 2) begin
                    chk($sformatf("ce%0d_%0d.v", i, h),
                        32'(bus.valid_o), 32'd1);
                    chk($sformatf("ce%0d_%0d.o", i, h), 32'(bus.o),
                        32'(16'h3C00 + 16'(i - 2) * 16'h0400));
                end else begin
                    chk($sformatf("ce%0d_%0d.v", i, h),
                        32'(bus.valid_o), 32'd0);
                end
                if (h == 0) begin
                    bus.ce = 1'b0;
                    drive(1'b1, 16'h7BFF, 16'h0009);
                    step();
                end
            end
        end
        bus.ce = 1'b1;
        drive(1'b0, 16'h0, 16'h0);
        step();
        chk("ce_drain.v", 32'(bus.valid_o), 32'd0);
        step();

        // Reset with two ops in flight behind a visible result.
        drive(1'b1, 16'h3C00, 16'h0001);
        step();
        drive(1'b1, 16'h3C00, 16'h0002);
        step();
        drive(1'b1, 16'h3C00, 16'h0003);
        step();
        chk("pre_rst.v", 32'(bus.valid_o), 32'd1);
        chk("pre_rst.o", 32'(bus.o), 32'h4000);
        drive(1'b0, 16'h0, 16'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.v", 32'(bus.valid_o), 32'd0);
        chk("arst.o", 32'(bus.o), 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("post_rst%0d.v", k), 32'(bus.valid_o), 32'd0);
        end
        run_op("post_rst", 16'h3C00, 16'h0002, 16'h4400, 5'b1_0000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
